// File: rtl/paralelo_serie_pkg.sv
// Definitions shared by the parallel-to-serial transmitter and this receiver.
// Both ends must agree on the idle/comma character and on the byte width.
// Contents: comma value, byte width, receiver FSM state encoding.
package paralelo_serie_pkg;

    localparam int              BYTE_W     = 8;
    localparam logic [BYTE_W-1:0] COMMA_K285 = 8'hBC;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

endpackage

// File: rtl/serie_paralelo_comma_detect.sv
// Serial bit shifter with comma compare: keeps the last BYTE_W received bits
// (newest bit in the LSB) and flags when they equal the comma character.
// Ports: clk_8f/reset_L (sync, active-low), data_in serial bit, sr window, is_comma flag.
module comma_detect
    import paralelo_serie_pkg::*;
#(
    parameter logic [BYTE_W-1:0] COMMA = COMMA_K285
) (
    input  logic              clk_8f,
    input  logic              reset_L,
    input  logic              data_in,
    output logic [BYTE_W-1:0] sr,
    output logic              is_comma
);

    logic [BYTE_W-1:0] sr_q;
    logic [BYTE_W-1:0] sr_d;

    // MSB-first serial: the first bit of a byte ends up in sr[7].
    always_comb begin
        sr_d = {sr_q[BYTE_W-2:0], data_in};
    end

    always_ff @(posedge clk_8f) begin
        if (!reset_L) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign sr       = sr_q;
    assign is_comma = (sr_q == COMMA);

endmodule

// File: rtl/serie_paralelo.sv
// Serial-to-parallel receiver: aligns to the comma character, then strobes each
// recovered data byte (valid_out) or idle comma (idle_out) for one cycle.
// Ports: clk_8f bit clock, reset_L sync active-low, data_in serial MSB-first,
// data_out/valid_out/idle_out byte outputs, active high once locked.
module serie_paralelo
    import paralelo_serie_pkg::*;
#(
    parameter logic [BYTE_W-1:0] COMMA    = COMMA_K285,
    parameter int                BC_COUNT = 4
) (
    input  logic              clk_8f,
    input  logic              reset_L,
    input  logic              data_in,
    output logic [BYTE_W-1:0] data_out,
    output logic              valid_out,
    output logic              idle_out,
    output logic              active
);

    localparam logic [2:0] BC_TARGET = 3'(BC_COUNT);

    logic [BYTE_W-1:0] sr;
    logic              is_comma;

    state_t            state_q,    state_d;
    logic [2:0]        phase_q,    phase_d;
    logic [2:0]        bc_cnt_q,   bc_cnt_d;
    logic [BYTE_W-1:0] data_out_q, data_out_d;
    logic              valid_q,    valid_d;
    logic              idle_q,     idle_d;

    logic              boundary;
    logic [2:0]        bc_cnt_inc;

    comma_detect #(
        .COMMA (COMMA)
    ) u_comma_detect (
        .clk_8f   (clk_8f),
        .reset_L  (reset_L),
        .data_in  (data_in),
        .sr       (sr),
        .is_comma (is_comma)
    );

    // phase == 0 means the byte just completed is sitting whole in sr.
    assign boundary   = (phase_q == 3'd0);
    assign bc_cnt_inc = bc_cnt_q + 3'd1;

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q + 3'd1;   // wraps 7 -> 0 naturally
        bc_cnt_d   = bc_cnt_q;
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        idle_d     = 1'b0;

        case (state_q)
            SEARCH: begin
                // Bit-by-bit hunt; phase is meaningless until a comma is seen.
                phase_d  = 3'd0;
                bc_cnt_d = 3'd0;
                if (is_comma) begin
                    // The cycle that saw the comma is itself a boundary (phase 0),
                    // so the count restarts at 1 on the next cycle.
                    phase_d  = 3'd1;
                    bc_cnt_d = 3'd1;
                    state_d  = (BC_TARGET == 3'd1) ? ACTIVE : ALIGN;
                end
            end

            ALIGN: begin
                // Only whole-byte boundaries are examined; a single non-comma
                // there means the earlier match was an alias inside data.
                if (boundary) begin
                    if (is_comma) begin
                        bc_cnt_d = bc_cnt_inc;
                        if (bc_cnt_inc == BC_TARGET) begin
                            state_d = ACTIVE;
                        end
                    end else begin
                        state_d  = SEARCH;
                        bc_cnt_d = 3'd0;
                        phase_d  = 3'd0;
                    end
                end
            end

            ACTIVE: begin
                // No loss-of-lock detection: only reset leaves this state.
                if (boundary) begin
                    if (is_comma) begin
                        idle_d = 1'b1;
                    end else begin
                        data_out_d = sr;
                        valid_d    = 1'b1;
                    end
                end
            end

            default: begin
                state_d  = SEARCH;
                phase_d  = 3'd0;
                bc_cnt_d = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk_8f) begin
        if (!reset_L) begin
            state_q    <= SEARCH;
            phase_q    <= 3'd0;
            bc_cnt_q   <= 3'd0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            idle_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            bc_cnt_q   <= bc_cnt_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            idle_q     <= idle_d;
        end
    end

    assign data_out  = data_out_q;
    assign valid_out = valid_q;
    assign idle_out  = idle_q;
    assign active    = (state_q == ACTIVE);

endmodule

// File: doc/serie_paralelo.md
# serie_paralelo

Serial-to-parallel receiver that sits directly downstream of the parallel-to-serial transmitter on the same link. It samples one serial bit per `clk_8f` cycle, recovers byte alignment from the `0xBC` idle/comma character the transmitter sends when it has no valid data, and emits each recovered data byte with a one-cycle valid strobe. Everything runs in the `clk_8f` domain. No `clk_f` is used; byte timing is derived internally.

## Interface
- `COMMA`, default `8'hBC`: idle/comma character used for alignment and idle detection.
- `BC_COUNT`, default `4`: number of consecutive aligned commas required to declare the link active. Range 1..7.

- `clk_8f` input 1: bit clock. All logic is on the rising edge.
- `reset_L` input 1: synchronous reset, active-low. One clock; reset is synchronous and active-low.
- `data_in` input 1: serial bit, MSB-first per byte.
- `data_out` output 8: recovered data byte. Holds its value between strobes.
- `valid_out` output 1: one-cycle pulse when `data_out` carries a new non-comma byte.
- `idle_out` output 1: one-cycle pulse when an aligned comma is received in ACTIVE.
- `active` output 1: high while in the ACTIVE state.

## Operation
- Shift register `sr[7:0]`: `sr <= {sr[6:0], data_in}` on every cycle, in every non-reset state.
- Phase counter `phase[2:0]`, comma counter `bc_cnt[2:0]`.
- State SEARCH (reset state):
  - Compare `sr == COMMA` every cycle.
  - On a match: `phase <= 1`, `bc_cnt <= 1`, go to ALIGN. If `BC_COUNT == 1`, go directly to ACTIVE.
- State ALIGN:
  - `phase` increments each cycle and wraps from 7 to 0.
  - A boundary is any cycle with `phase == 0`; at that point `sr` holds a full aligned byte.
  - At a boundary with `sr == COMMA`: `bc_cnt++`. When the new count equals `BC_COUNT`, go to ACTIVE.
  - At a boundary with `sr != COMMA`: return to SEARCH and clear `bc_cnt`.
  - No outputs pulse in ALIGN.
- State ACTIVE:
  - At each boundary with `sr != COMMA`: `data_out <= sr`, `valid_out <= 1`.
  - At each boundary with `sr == COMMA`: `idle_out <= 1`; `data_out` is unchanged.
  - `valid_out` and `idle_out` are 0 on all other cycles.
  - ACTIVE is left only by reset. There is no loss-of-lock detection.
- Comma aliasing inside pre-lock data in SEARCH is accepted. ALIGN's consecutive-comma check rejects false alignment.

## Timing
- Reset: on a rising edge with `reset_L == 0`, the next-state values are `sr = 0`, `phase = 0`, `bc_cnt = 0`, state SEARCH, `data_out = 8'h00`, `valid_out = 0`, `idle_out = 0`, `active = 0`.
- Reset asserted mid-byte or in ACTIVE takes effect at that edge. Any partial byte is discarded and alignment is reacquired from SEARCH.
- Latency: the last bit of a byte is sampled into `sr` at edge N, which makes `phase == 0`. `data_out`, `valid_out` and `idle_out` are registered at edge N+1.
- End-to-end from the byte's first bit to the strobe: 9 `clk_8f` cycles.
- `active` rises at the edge where the `BC_COUNT`-th comma is counted. That comma produces no `idle_out`.
- Throughput: at most one strobe every 8 cycles. `valid_out` and `idle_out` are never high together.

## Structure
- Shared package `paralelo_serie_pkg` holds:
  - `COMMA_K285 = 8'hBC`
  - state encoding `SEARCH = 2'd0`, `ALIGN = 2'd1`, `ACTIVE = 2'd2`
  - `BYTE_W = 8`
- Package is shared with the transmitter so both ends use the same idle character.
- One natural sub-module, `comma_detect`: 8-bit shift register plus `sr == COMMA` compare output. The FSM, counters and output registers live in the top.

## Test plan
- Reset: hold `reset_L = 0` for 3 cycles while driving random bits -> all outputs 0, state SEARCH; release -> no strobes until a comma is found.
- Lock and data: send 4×`0xBC`, then `0xA5`, `0x3C`, MSB-first -> `active` rises after the 4th comma; `valid_out` pulses with `data_out = 0xA5`, then 8 cycles later `0x3C`; latency is 9 cycles from the first bit.
- Misaligned start: prepend 3 junk bits `101` before 4×`0xBC` + `0x11` -> lock still achieved; `data_out = 0x11` on the correct boundary.
- Broken comma run: send `0xBC`, `0xBC`, `0x55`, then 4×`0xBC`, `0x77` -> returns to SEARCH at `0x55`; `active` rises only after the later 4 commas; only `0x77` is strobed.
- Idle in ACTIVE: after lock send `0x01`, `0xBC`, `0x02` -> `valid_out` for `0x01`; `idle_out` for the comma with `data_out` still `0x01`; then `valid_out` for `0x02`.
- Reset mid-operation: assert `reset_L = 0` at bit 4 of a data byte in ACTIVE -> outputs clear at that edge; relock is required before any new `valid_out`.
